// File: rtl/spi_master_multi_if.sv
// CPU device-bus bundle for spi_master_multi.
// The bus master (CPU side) drives the access strobe, direction, index and
// write data; the peripheral returns registered read data.
interface spi_master_multi_if #(
    parameter int DATA_W = 8
);
    logic              i_en;
    logic              i_wr;
    logic [3:0]        i_addr;
    logic [DATA_W-1:0] i_data;
    logic [DATA_W-1:0] o_data;

    modport master (
        output i_en,
        output i_wr,
        output i_addr,
        output i_data,
        input  o_data
    );

    modport slave (
        input  i_en,
        input  i_wr,
        input  i_addr,
        input  i_data,
        output o_data
    );
endinterface

// File: rtl/spi_master_multi.sv
// Memory-mapped SPI master with NUM_SS active-low selects, run-time CPOL/CPHA,
// bit order and SCLK divider, receive-valid/overrun flags and a level irq.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | no frame; SCLK parked at CPOL, DATA_OUT write starts a frame
// ST_SHIFT | dividing i_clk, toggling SCLK, shifting MOSI / sampling MISO
// ST_DONE  | one cycle: publish received frame, update rx_valid/overrun
module spi_master_multi #(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    spi_master_multi_if.slave bus,
    output logic              o_SCLK,
    output logic              o_MOSI,
    input  logic              i_MISO,
    output logic [NUM_SS-1:0] o_SS_n,
    output logic              o_irq
);

    localparam int TOG_W = $clog2(2 * DATA_W) + 1;
    localparam logic [TOG_W-1:0] TOG_LAST  = TOG_W'(2 * DATA_W);
    localparam logic [TOG_W-1:0] TOG_THREE = TOG_W'(3);

    localparam logic [3:0] A_STATUS = 4'd0;
    localparam logic [3:0] A_DOUT   = 4'd1;
    localparam logic [3:0] A_DIN    = 4'd2;
    localparam logic [3:0] A_CTRL   = 4'd3;
    localparam logic [3:0] A_CLKDIV = 4'd4;
    localparam logic [3:0] A_SSSEL  = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t              state_q;
    logic [4:0]          ctrl_q,   ctrl_d;     // {irq_en, lsb_first, ss_en, cpol, cpha}
    logic [DIV_W-1:0]    clkdiv_q, clkdiv_d;
    logic [DATA_W-1:0]   ss_sel_q, ss_sel_d;
    logic [NUM_SS-1:0]   ss_n_q,   ss_n_d;
    logic [DATA_W-1:0]   rdata_q,  rdata_d;
    logic [DATA_W-1:0]   dout_q;
    logic [DATA_W-1:0]   din_q;
    logic [DATA_W-1:0]   tx_sh_q;
    logic [DATA_W-1:0]   rx_sh_q;
    logic [DIV_W-1:0]    cnt_q;
    logic [TOG_W-1:0]    tog_q;
    logic [TOG_W-1:0]    tog_nx;
    logic                sclk_q;
    logic                mosi_q;
    logic                rx_valid_q;
    logic                overrun_q;

    logic busy, wr_en, rd_en, start, rd_din, lead, shift_now, sample_now;

    assign busy   = (state_q != ST_IDLE);
    assign wr_en  = bus.i_en &  bus.i_wr;
    assign rd_en  = bus.i_en & ~bus.i_wr;
    assign start  = wr_en && (bus.i_addr == A_DOUT) && !busy;
    assign rd_din = rd_en && (bus.i_addr == A_DIN);

    // Toggle bookkeeping: odd toggle numbers are leading edges.
    assign tog_nx     = tog_q + 1'b1;
    assign lead       = tog_nx[0];
    assign shift_now  = ctrl_q[0] ? (lead && (tog_nx >= TOG_THREE))
                                  : (!lead && (tog_nx <= TOG_LAST - TOG_THREE + 1'b1));
    assign sample_now = ctrl_q[0] ? !lead : lead;

    // Next values of the config registers, slave selects and read data.
    always_comb begin
        ctrl_d   = ctrl_q;
        clkdiv_d = clkdiv_q;
        ss_sel_d = ss_sel_q;
        ss_n_d   = '1;
        rdata_d  = '0;
        if (wr_en && bus.i_addr == A_CTRL) begin
            // Mode and bit order are frozen during a frame; ss_en and irq_en are not.
            if (busy) ctrl_d = {bus.i_data[4], ctrl_q[3], bus.i_data[2], ctrl_q[1:0]};
            else      ctrl_d = bus.i_data[4:0];
        end
        if (wr_en && bus.i_addr == A_CLKDIV && !busy) clkdiv_d = bus.i_data[DIV_W-1:0];
        if (wr_en && bus.i_addr == A_SSSEL)           ss_sel_d = bus.i_data;
        for (int k = 0; k < NUM_SS; k++) begin
            if (ctrl_d[2] && ss_sel_d == DATA_W'(k)) ss_n_d[k] = 1'b0;
        end
        case (bus.i_addr)
            A_STATUS: rdata_d = {{(DATA_W-3){1'b0}}, overrun_q, rx_valid_q, busy};
            A_DOUT:   rdata_d = dout_q;
            A_DIN:    rdata_d = din_q;
            A_CTRL:   rdata_d = DATA_W'(ctrl_q);
            A_CLKDIV: rdata_d = DATA_W'(clkdiv_q);
            A_SSSEL:  rdata_d = ss_sel_q;
            default:  rdata_d = '0;
        endcase
    end

    // Register file, frame FSM and SPI pin registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            clkdiv_q   <= '1;
            ss_sel_q   <= '0;
            ss_n_q     <= '1;
            rdata_q    <= '0;
            dout_q     <= '0;
            din_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            cnt_q      <= '0;
            tog_q      <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            clkdiv_q <= clkdiv_d;
            ss_sel_q <= ss_sel_d;
            ss_n_q   <= ss_n_d;
            if (rd_en) rdata_q <= rdata_d;
            if (rd_din) begin
                rx_valid_q <= 1'b0;
                overrun_q  <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    sclk_q <= ctrl_d[1];
                    if (start) begin
                        dout_q  <= bus.i_data;
                        tx_sh_q <= bus.i_data;
                        mosi_q  <= ctrl_q[3] ? bus.i_data[0] : bus.i_data[DATA_W-1];
                        cnt_q   <= '0;
                        tog_q   <= '0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_q == clkdiv_q) begin
                        cnt_q  <= '0;
                        sclk_q <= ~sclk_q;
                        tog_q  <= tog_nx;
                        if (shift_now) begin
                            if (ctrl_q[3]) begin
                                tx_sh_q <= tx_sh_q >> 1;
                                mosi_q  <= tx_sh_q[1];
                            end else begin
                                tx_sh_q <= tx_sh_q << 1;
                                mosi_q  <= tx_sh_q[DATA_W-2];
                            end
                        end
                        if (sample_now) begin
                            if (ctrl_q[3]) rx_sh_q <= {i_MISO, rx_sh_q[DATA_W-1:1]};
                            else           rx_sh_q <= {rx_sh_q[DATA_W-2:0], i_MISO};
                        end
                        if (tog_nx == TOG_LAST) state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    din_q      <= rx_sh_q;
                    rx_valid_q <= 1'b1;
                    // A DATA_IN read in this cycle consumes the old frame, so no overrun.
                    overrun_q  <= rd_din ? 1'b0 : rx_valid_q;
                    state_q    <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.o_data = rdata_q;
    assign o_SCLK     = sclk_q;
    assign o_MOSI     = mosi_q;
    assign o_SS_n     = ss_n_q;
    assign o_irq      = rx_valid_q & ctrl_q[4];

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi: register reset values, a mode-0 frame
// against a slave model, a table of loopback frames in all modes/bit orders,
// and hand-written sequences for overrun, DONE-cycle read, busy writes,
// mid-frame reset and slave-select decode.
module tb_spi_master_multi;
    localparam int DW = 8;
    localparam int NS = 4;
    localparam int DVW = 8;
    localparam int CP = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          miso;
    logic          sclk, mosi, irq;
    logic [NS-1:0] ss_n;

    always #(CP/2) clk = ~clk;

    spi_master_multi_if #(.DATA_W(DW)) bus ();

    spi_master_multi #(.DATA_W(DW), .NUM_SS(NS), .DIV_W(DVW)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .o_SCLK  (sclk),
        .o_MOSI  (mosi),
        .i_MISO  (miso),
        .o_SS_n  (ss_n),
        .o_irq   (irq)
    );

    int  n_vec = 0;
    int  n_bad = 0;
    time t_wr  = 0;

    // SCLK monitor / mode-0 slave model
    logic       loopback = 1'b1;
    logic       cap_en   = 1'b0;
    logic [7:0] slv_bits = 8'h00;
    logic [7:0] mosi_cap = 8'h00;
    logic       sclk_prev = 1'b0;
    int         slv_idx = 0;
    int         tog_cnt = 0;
    int         bad_gap = 0;
    time        t_first = 0;
    time        t_last  = 0;

    assign miso = loopback ? mosi : ((slv_idx < 8) ? slv_bits[3'(7 - slv_idx)] : 1'b0);

    always @(negedge clk) begin
        if (!cap_en) begin
            tog_cnt  = 0;
            bad_gap  = 0;
            mosi_cap = 8'h00;
            slv_idx  = 0;
        end else if (sclk !== sclk_prev) begin
            if (tog_cnt == 0) t_first = $time;
            else if ($time - t_last != 2 * CP) bad_gap++;
            t_last = $time;
            tog_cnt++;
            if (sclk) mosi_cap = {mosi_cap[6:0], mosi};
            else      slv_idx++;
        end
        sclk_prev = sclk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Bus tasks are entered at a negedge; the access happens on the next posedge.
    task automatic wr(input logic [3:0] a, input logic [DW-1:0] d);
        bus.i_en = 1'b1; bus.i_wr = 1'b1; bus.i_addr = a; bus.i_data = d;
        @(posedge clk);
        t_wr = $time;
        @(negedge clk);
        bus.i_en = 1'b0; bus.i_wr = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [DW-1:0] d);
        bus.i_en = 1'b1; bus.i_wr = 1'b0; bus.i_addr = a;
        @(negedge clk);
        bus.i_en = 1'b0;
        d = bus.o_data;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [DW-1:0] exp);
        logic [DW-1:0] d;
        rd(a, d);
        check(name, 32'(d), 32'(exp));
    endtask

    typedef struct {
        logic [3:0]    addr;
        logic [DW-1:0] exp;
    } rst_vec_t;

    typedef struct {
        logic [4:0] ctrl;
        logic [7:0] div;
        logic [7:0] tx;
        logic [7:0] exp_rx;
        logic       exp_idle;
    } lb_vec_t;

    rst_vec_t rst_tab[7];
    lb_vec_t  lb_tab[7];

    initial begin
        rst_tab[0] = '{4'd0, 8'h00};
        rst_tab[1] = '{4'd1, 8'h00};
        rst_tab[2] = '{4'd2, 8'h00};
        rst_tab[3] = '{4'd3, 8'h00};
        rst_tab[4] = '{4'd4, 8'hFF};
        rst_tab[5] = '{4'd5, 8'h00};
        rst_tab[6] = '{4'd9, 8'h00};

        //            ctrl    div   tx     rx     idle
        lb_tab[0] = '{5'h05, 8'd1, 8'h81, 8'h81, 1'b0};   // mode 1
        lb_tab[1] = '{5'h06, 8'd0, 8'h7E, 8'h7E, 1'b1};   // mode 2
        lb_tab[2] = '{5'h07, 8'd2, 8'h81, 8'h81, 1'b1};   // mode 3
        lb_tab[3] = '{5'h0C, 8'd1, 8'h7E, 8'h7E, 1'b0};   // mode 0, lsb first
        lb_tab[4] = '{5'h0F, 8'd0, 8'h81, 8'h81, 1'b1};   // mode 3, lsb first
        lb_tab[5] = '{5'h09, 8'd3, 8'hA5, 8'hA5, 1'b0};   // mode 1, lsb first
        lb_tab[6] = '{5'h0E, 8'd1, 8'h3C, 8'h3C, 1'b1};   // mode 2, lsb first

        bus.i_en = 1'b0; bus.i_wr = 1'b0; bus.i_addr = 4'd0; bus.i_data = '0;

        // Reset state
        @(negedge clk);
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_ss_n", 32'(ss_n), 32'hF);
        check("rst_irq",  32'(irq),  32'd0);
        check("rst_odata", 32'(bus.o_data), 32'd0);
        rst_n = 1'b1;
        idle(1);
        for (int i = 0; i < 7; i++) rd_chk($sformatf("rst_reg%0d", rst_tab[i].addr), rst_tab[i].addr, rst_tab[i].exp);

        // Mode 0 frame, CLKDIV=1, slave 2, slave returns 0x3C
        wr(4'd5, 8'd2);
        wr(4'd3, 8'h14);
        check("m0_ss_n", 32'(ss_n), 32'hB);
        wr(4'd4, 8'd1);
        loopback = 1'b0;
        slv_bits = 8'h3C;
        cap_en   = 1'b1;
        idle(1);
        wr(4'd1, 8'hA5);
        rd_chk("m0_busy_first", 4'd0, 8'h01);
        idle(31);
        rd_chk("m0_busy_last", 4'd0, 8'h01);
        rd_chk("m0_status_done", 4'd0, 8'h02);
        check("m0_irq", 32'(irq), 32'd1);
        check("m0_toggles", 32'(tog_cnt), 32'd16);
        check("m0_gap", 32'(bad_gap), 32'd0);
        check("m0_first_tog", 32'(t_first - t_wr), 32'(2 * CP + CP / 2));
        check("m0_mosi_bits", 32'(mosi_cap), 32'hA5);
        check("m0_sclk_idle", 32'(sclk), 32'd0);
        rd_chk("m0_data_in", 4'd2, 8'h3C);
        check("m0_irq_clr", 32'(irq), 32'd0);
        cap_en   = 1'b0;
        loopback = 1'b1;

        // Loopback table over modes and bit orders
        for (int i = 0; i < 7; i++) begin
            wr(4'd3, {3'b000, lb_tab[i].ctrl});
            wr(4'd4, lb_tab[i].div);
            idle(2);
            check($sformatf("lb%0d_idle_pre", i), 32'(sclk), 32'(lb_tab[i].exp_idle));
            wr(4'd1, lb_tab[i].tx);
            idle(2 * DW * (int'(lb_tab[i].div) + 1) + 1);
            rd_chk($sformatf("lb%0d_status", i), 4'd0, 8'h02);
            rd_chk($sformatf("lb%0d_rx", i), 4'd2, lb_tab[i].exp_rx);
            check($sformatf("lb%0d_idle_post", i), 32'(sclk), 32'(lb_tab[i].exp_idle));
        end

        // Two frames without reading DATA_IN -> overrun
        wr(4'd3, 8'h04);
        wr(4'd4, 8'd0);
        wr(4'd1, 8'h5A);
        idle(17);
        wr(4'd1, 8'hC3);
        idle(17);
        rd_chk("ovr_status", 4'd0, 8'h06);
        rd_chk("ovr_data_in", 4'd2, 8'hC3);
        rd_chk("ovr_cleared", 4'd0, 8'h00);

        // DATA_IN read in the DONE cycle of a frame that would overrun
        wr(4'd1, 8'h12);
        idle(17);
        wr(4'd1, 8'h34);
        idle(16);
        rd_chk("done_rd_old", 4'd2, 8'h12);
        rd_chk("done_rd_status", 4'd0, 8'h02);
        rd_chk("done_rd_new", 4'd2, 8'h34);
        rd_chk("done_rd_clr", 4'd0, 8'h00);

        // Writes while busy: DATA_OUT and CLKDIV ignored, CTRL only bits 2/4
        wr(4'd4, 8'd1);
        wr(4'd3, 8'h04);
        wr(4'd1, 8'h22);
        idle(3);
        wr(4'd1, 8'h11);
        wr(4'd4, 8'd5);
        wr(4'd3, 8'h13);
        idle(26);
        rd_chk("bw_busy_last", 4'd0, 8'h01);
        rd_chk("bw_status_done", 4'd0, 8'h02);
        rd_chk("bw_data_in", 4'd2, 8'h22);
        rd_chk("bw_data_out", 4'd1, 8'h22);
        rd_chk("bw_clkdiv", 4'd4, 8'd1);
        rd_chk("bw_ctrl", 4'd3, 8'h10);

        // Reset asserted right after toggle 7
        wr(4'd3, 8'h04);
        wr(4'd4, 8'd1);
        wr(4'd1, 8'hFF);
        idle(14);
        check("mr_sclk_pre", 32'(sclk), 32'd1);
        check("mr_mosi_pre", 32'(mosi), 32'd1);
        check("mr_ss_pre", 32'(ss_n), 32'hB);
        rst_n = 1'b0;
        #1;
        check("mr_sclk", 32'(sclk), 32'd0);
        check("mr_mosi", 32'(mosi), 32'd0);
        check("mr_ss_n", 32'(ss_n), 32'hF);
        check("mr_irq", 32'(irq), 32'd0);
        check("mr_odata", 32'(bus.o_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(40);
        rd_chk("mr_status", 4'd0, 8'h00);
        rd_chk("mr_clkdiv", 4'd4, 8'hFF);
        wr(4'd3, 8'h00);
        wr(4'd4, 8'd0);
        wr(4'd1, 8'h3C);
        idle(17);
        rd_chk("mr_new_status", 4'd0, 8'h02);
        rd_chk("mr_new_rx", 4'd2, 8'h3C);

        // Slave select decode and unmapped read
        wr(4'd3, 8'h04);
        wr(4'd5, 8'd7);
        check("ss_out_of_range", 32'(ss_n), 32'hF);
        wr(4'd5, 8'd0);
        check("ss_sel0", 32'(ss_n), 32'hE);
        wr(4'd3, 8'h00);
        check("ss_disabled", 32'(ss_n), 32'hF);
        rd_chk("unmapped_rd", 4'd9, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
